// File: rtl/instr_encoder.sv
// MIPS field packer feeding a small FIFO of {word, word-address} entries
// toward the instruction-memory loader.
module instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                opCode,
  input  logic [4:0]                rs,
  input  logic [4:0]                rt,
  input  logic [4:0]                rd,
  input  logic [4:0]                shamt,
  input  logic [5:0]                funct,
  input  logic [15:0]               address,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               instruction,
  output logic [ADDR_W-1:0]         instr_addr,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]       word_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];

  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic        push;
  logic        pop;
  logic [31:0] packed_w;

  assign in_ready    = rst_n && (cnt_q < FULL);
  assign out_valid   = (cnt_q != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign instruction = word_q[rd_q];
  assign instr_addr  = tag_q[rd_q];
  assign count       = cnt_q;

  // R-type puts rd in [20:16] and rt in [15:11] to match the splitter
  always_comb begin
    packed_w = {opCode, rs, rt, address};
    if (opCode == 6'b000000) begin
      packed_w = {6'b000000, rs, rd, rt, shamt, funct};
    end
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (flush) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      addr_d = BASE;
    end else begin
      if (push) begin
        wr_d   = wr_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      addr_q <= BASE;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (push && !flush) begin
      word_q[wr_q] <= packed_w;
      tag_q[wr_q]  <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and random checks for instr_encoder (DEPTH=4, ADDR_W=4).
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] address;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [3:0]  instr_addr;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  instr_encoder #(
    .DEPTH(4),
    .ADDR_W(4),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .opCode(opCode),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .shamt(shamt),
    .funct(funct),
    .address(address),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .instruction(instruction),
    .instr_addr(instr_addr),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [3:0]  tag;
  } tup_t;

  tup_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic [15:0] a);
    opCode  = op;
    rs      = s;
    rt      = t;
    address = a;
    rd      = 5'($urandom);
    shamt   = 5'($urandom);
    funct   = 6'($urandom);
  endtask

  logic [31:0] exp_fill [5];
  logic [20:0] obs_f;
  logic [20:0] exp_f;
  logic [3:0]  tag_n;
  logic        do_push;
  logic        do_pop;
  int          pushed;
  int          cyc;
  tup_t        t;
  tup_t        h;

  initial begin
    exp_fill[0] = 32'h20221000;
    exp_fill[1] = 32'h20431001;
    exp_fill[2] = 32'h20641002;
    exp_fill[3] = 32'h20851003;
    exp_fill[4] = 32'h20A61004;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opCode = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
    funct = '0; address = '0;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_instr_addr", 32'(instr_addr), 32'd0);

    // R-type pack
    rst_n = 1'b1;
    in_valid = 1'b1;
    opCode = 6'd0; rs = 5'd1; rd = 5'd2; rt = 5'd3;
    shamt = 5'd0; funct = 6'h20; address = 16'hBEEF;
    #1;
    chk("r_in_ready", 32'(in_ready), 32'd1);
    chk("r_no_bypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("r_out_valid", 32'(out_valid), 32'd1);
    chk("r_word", instruction, 32'h00221820);
    chk("r_addr", 32'(instr_addr), 32'd0);
    chk("r_count", 32'(count), 32'd1);
    step();
    chk("r_hold_word", instruction, 32'h00221820);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("r_pop_valid", 32'(out_valid), 32'd0);
    chk("r_pop_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("underflow_count", 32'(count), 32'd0);

    // I-type pack
    in_valid = 1'b1;
    set_i(6'h23, 5'd29, 5'd8, 16'h0004);
    step();
    in_valid = 1'b0;
    chk("i_word", instruction, 32'h8FA80004);
    chk("i_addr", 32'(instr_addr), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);

    // Fill and backpressure
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      set_i(6'h08, 5'(k + 1), 5'(k + 2), 16'(16'h1000 + k));
      #1;
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    set_i(6'h08, 5'd5, 5'd6, 16'h1004);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    #1;
    chk("full_pop_no_push", 32'(in_ready), 32'd0);
    for (int j = 0; j < 5; j++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_word", instruction, exp_fill[j]);
      chk("drain_addr", 32'(instr_addr), 32'(j));
      step();
      if (j == 1) in_valid = 1'b0;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Address wrap with ADDR_W=4
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      set_i(6'h0F, 5'(i), 5'(i), 16'(i));
      step();
      chk("wrap_addr", 32'(instr_addr), 32'(i % 16));
      chk("wrap_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // Flush mid-stream with concurrent push
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      set_i(6'h04, 5'd1, 5'd2, 16'(i));
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    set_i(6'h04, 5'd9, 5'd9, 16'hDEAD);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("mid_flush_count", 32'(count), 32'd0);
    chk("mid_flush_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    set_i(6'h23, 5'd29, 5'd8, 16'h0004);
    step();
    in_valid = 1'b0;
    chk("post_flush_addr", 32'(instr_addr), 32'd0);
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_word", instruction, 32'h8FA80004);

    // Same scenario with reset
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      set_i(6'h04, 5'd3, 5'd4, 16'(i));
      step();
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready_low", 32'(in_ready), 32'd0);
    chk("rst_mid_word", instruction, 32'h0);
    rst_n = 1'b1;
    set_i(6'h08, 5'd1, 5'd2, 16'h1000);
    step();
    in_valid = 1'b0;
    chk("post_rst_addr", 32'(instr_addr), 32'd0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_word", instruction, 32'h20221000);

    // Random round trip
    flush = 1'b1;
    step();
    flush = 1'b0;
    pushed = 0;
    tag_n = 4'd0;
    cyc = 0;
    while ((pushed < 200 || q.size() != 0) && cyc < 3000) begin
      in_valid = (pushed < 200) && ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) opCode = 6'd0;
      else opCode = 6'($urandom_range(1, 63));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      shamt = 5'($urandom); funct = 6'($urandom);
      address = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      do_push = in_valid && in_ready;
      do_pop = out_valid && out_ready;
      if (do_pop) begin
        if (q.size() == 0) begin
          chk("rt_spurious_pop", 32'd1, 32'd0);
        end else begin
          h = q.pop_front();
          chk("rt_op", 32'(instruction[31:26]), 32'(h.op));
          chk("rt_rs", 32'(instruction[25:21]), 32'(h.rs));
          if (instruction[31:26] == 6'd0) begin
            obs_f = {instruction[20:16], instruction[15:11],
                     instruction[10:6], instruction[5:0]};
            exp_f = {h.rd, h.rt, h.sh, h.fn};
          end else begin
            obs_f = {instruction[20:16], instruction[15:0]};
            exp_f = {h.rt, h.imm};
          end
          chk("rt_fields", 32'(obs_f), 32'(exp_f));
          chk("rt_addr", 32'(instr_addr), 32'(h.tag));
        end
      end
      if (do_push) begin
        t.op = opCode; t.rs = rs; t.rt = rt; t.rd = rd;
        t.sh = shamt; t.fn = funct; t.imm = address; t.tag = tag_n;
        q.push_back(t);
        tag_n = tag_n + 4'd1;
        pushed++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rt_timeout", 32'(cyc < 3000), 32'd1);
    chk("rt_pushed", 32'(pushed), 32'd200);
    chk("rt_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
